miner_job_feeder: RTL and testbench
===================================

// Module: miner_job_feeder
// PURPOSE
// - Job-side counterpart of the hashing miner core: holds the header blob, launches jobs and collects results.
// - Buffers the host-written header blob and issues the job start pulse with nonce and byte count.
// - Serves 512-bit message chunks on each miner chunk request and rewinds to chunk 0 after every completed hash.
// - Latches the winning nonce/hash, clears the miner and reports done/found/exhausted to the host.
// PARAMETERS
// - MAX_CHUNKS      16  max 64-byte chunks in the blob buffer (1024 B)
// - NONCE_BYTE_LEN  24  nonce width in bytes
// PORTS
// - Clk            in   1     clock
// - Rst_n          in   1     async reset, active-low
// - WrEn_I         in   1     host blob word write strobe
// - WrAddr_I       in   8     word index: chunk = [7:4], word = [3:0]
// - WrData_I       in   32    blob word
// - Start_I        in   1     start job (pulse)
// - Abort_I        in   1     abort job (pulse)
// - ByteNum_I      in   11    blob length in bytes; sampled on Start_I
// - Nonce_I        in   NONCE_BYTE_LEN*8  start nonce; sampled on Start_I
// - HashLimit_I    in   32    max hashes per job, 0 = unlimited
// - MinerUpdate_O  out  1     one-cycle job start pulse to the miner
// - MinerClear_O   out  1     one-cycle clear pulse to the miner
// - MinerMsg_O     out  16x32 current chunk, word 0 in [31:0]
// - MinerByteNum_O out  11    latched ByteNum
// - MinerNonce_O   out  NONCE_BYTE_LEN*8  latched start nonce
// - MinerNext_I    in   1     miner chunk request
// - MinerRdy_I     in   1     miner hash complete
// - MinerVld_I     in   1     miner found a valid nonce
// - MinerHash_I    in   256   winning hash
// - MinerNonce_I   in   NONCE_BYTE_LEN*8  winning nonce
// - MinerHashCnt_I in   32    miner hash counter
// - Busy_O         out  1     job active
// - Done_O         out  1     job finished; held until the next Start_I
// - Found_O        out  1     valid with Done_O: 1 = found, 0 = exhausted or limit hit
// - Err_O          out  1     sticky: bad ByteNum, or a write while Busy_O
// - ResNonce_O     out  NONCE_BYTE_LEN*8  winning nonce
// - ResHash_O      out  256   winning hash
// BEHAVIOUR
// - Reset values: all outputs 0; FSM in IDLE; chunk ptr 0. Buffer contents are not reset.
// - Writes:
//   - accepted only when Busy_O = 0; a write while busy is dropped and sets Err_O.
//   - WrAddr_I[7:4] >= MAX_CHUNKS: the write is dropped and sets Err_O.
// - FSM states: IDLE -> LAUNCH -> RUN -> DONE.
//   - IDLE/DONE + Start_I:
//     - ByteNum_I > MAX_CHUNKS*64: stay in place, set Err_O.
//     - otherwise: latch ByteNum/Nonce/limit, clear Done_O/Found_O/Err_O, go to LAUNCH.
//   - LAUNCH: MinerUpdate_O = 1 for exactly one cycle with MinerMsg_O = chunk 0; Busy_O = 1; next state RUN.
//   - RUN, first cycle with MinerVld_I = 1:
//     - latch MinerNonce_I and MinerHash_I; MinerClear_O pulses in the next cycle.
//     - go to DONE with Found_O = 1.
//   - RUN with limit hit (`FEEDER_TIMEOUT_EN` builds only): MinerClear_O pulse, DONE, Found_O = 0.
//   - Any state + Abort_I: MinerClear_O pulse, go to IDLE, Done_O = 0.
// - Priority on simultaneous events: Abort_I > MinerVld_I > limit > Start_I.
// - Start_I while Busy_O is ignored.
// - Chunk pointer:
//   - last = max(ceil(ByteNum/64), 1) - 1.
//   - MinerNext_I: ptr <= min(ptr+1, last); saturates and never wraps.
//   - MinerRdy_I: ptr <= 0. When asserted in the same cycle as MinerNext_I, MinerRdy_I wins.
//   - MinerMsg_O is registered from buffer[ptr]; valid 1 cycle after the ptr update.
// - Ports sampled only in RUN: MinerNext_I, MinerRdy_I and MinerVld_I are ignored outside RUN.
// - MinerHashCnt_I is compared unsigned against the latched limit with >=.
// - Bytes past ByteNum in the last chunk pass through as written; padding is the miner's job.
// CONFIGURATION
// - `FEEDER_TIMEOUT_EN` defined:
//   - in RUN, HashLimit != 0 and MinerHashCnt_I >= HashLimit ends the job with Found_O = 0.
// - `FEEDER_TIMEOUT_EN` undefined:
//   - HashLimit_I is ignored; a job ends only on find or abort.
// TESTING
// - Blob of 100 B in 2 chunks, Start_I -> one MinerUpdate_O pulse with chunk 0.
//   - one MinerNext_I -> chunk 1 one cycle later.
//   - MinerRdy_I -> chunk 0.
// - MinerVld_I with nonce 0x1234 and hash 0xAB.. -> ResNonce_O = 0x1234, ResHash_O = 0xAB..
//   - Done_O = Found_O = 1; one MinerClear_O pulse.
// - ByteNum 1100 + Start_I -> Err_O = 1, Busy_O stays 0, no MinerUpdate_O.
// - `FEEDER_TIMEOUT_EN` build, HashLimit 5, MinerHashCnt_I steps to 5 -> Done_O = 1, Found_O = 0, one clear pulse.
// - Abort_I and MinerVld_I in the same cycle -> IDLE, Done_O = 0, results unchanged; WrEn_I in RUN -> Err_O = 1.
// - Rst_n low mid-RUN -> all outputs 0, FSM IDLE; a new Start_I then relaunches normally.

Source files
------------

// File: rtl/miner_job_feeder.sv
// Job-side feeder for the hashing miner core: blob buffer, job launch, chunk serving and result capture.
// Optional hash-limit timeout is compiled in when `FEEDER_TIMEOUT_EN is defined.
module miner_job_feeder #(
  parameter int MAX_CHUNKS     = 16,
  parameter int NONCE_BYTE_LEN = 24
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          WrEn_I,
  input  logic [7:0]                    WrAddr_I,
  input  logic [31:0]                   WrData_I,
  input  logic                          Start_I,
  input  logic                          Abort_I,
  input  logic [10:0]                   ByteNum_I,
  input  logic [NONCE_BYTE_LEN*8-1:0]   Nonce_I,
  input  logic [31:0]                   HashLimit_I,
  output logic                          MinerUpdate_O,
  output logic                          MinerClear_O,
  output logic [511:0]                  MinerMsg_O,
  output logic [10:0]                   MinerByteNum_O,
  output logic [NONCE_BYTE_LEN*8-1:0]   MinerNonce_O,
  input  logic                          MinerNext_I,
  input  logic                          MinerRdy_I,
  input  logic                          MinerVld_I,
  input  logic [255:0]                  MinerHash_I,
  input  logic [NONCE_BYTE_LEN*8-1:0]   MinerNonce_I,
  input  logic [31:0]                   MinerHashCnt_I,
  output logic                          Busy_O,
  output logic                          Done_O,
  output logic                          Found_O,
  output logic                          Err_O,
  output logic [NONCE_BYTE_LEN*8-1:0]   ResNonce_O,
  output logic [255:0]                  ResHash_O
);

  localparam int          PTR_W     = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
  localparam int          NW        = NONCE_BYTE_LEN * 8;
  localparam logic [11:0] MAX_BYTES = 12'(MAX_CHUNKS * 64);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state_r, state_nx_s;

  logic [511:0]      buf_r [MAX_CHUNKS];
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  last_s;
  logic [11:0]       chunks_s;

  logic              update_r, clear_r, busy_r, done_r, found_r, err_r;
  logic [511:0]      msg_r;
  logic [10:0]       bytenum_r;
  logic [NW-1:0]     nonce_r;
  logic [31:0]       limit_r;
  logic [NW-1:0]     res_nonce_r;
  logic [255:0]      res_hash_r;

  logic              wr_ok_s, wr_bad_s, wr_range_bad_s;
  logic              start_ok_s, start_bad_s, find_s, limit_s, limit_hit_s;

`ifdef FEEDER_TIMEOUT_EN
  assign limit_hit_s = (limit_r != 32'd0) && (MinerHashCnt_I >= limit_r);
`else
  logic unused_s;
  assign unused_s    = ^{limit_r, MinerHashCnt_I};
  assign limit_hit_s = 1'b0;
`endif

  assign wr_range_bad_s = ({1'b0, WrAddr_I[7:4]} >= 5'(MAX_CHUNKS));
  assign wr_ok_s        = WrEn_I && !busy_r && !wr_range_bad_s;
  assign wr_bad_s       = WrEn_I && (busy_r || wr_range_bad_s);

  // A zero-length blob still occupies one chunk, so the last index floors at 0.
  assign chunks_s = ({1'b0, bytenum_r} + 12'd63) >> 6;
  assign last_s   = (chunks_s == 12'd0) ? '0 : (chunks_s[PTR_W-1:0] - PTR_W'(1));

  // Next-state and job events; Abort beats a find, a find beats the limit.
  always_comb begin
    state_nx_s  = state_r;
    start_ok_s  = 1'b0;
    start_bad_s = 1'b0;
    find_s      = 1'b0;
    limit_s     = 1'b0;
    if (Abort_I) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (Start_I) begin
            if ({1'b0, ByteNum_I} > MAX_BYTES) begin
              start_bad_s = 1'b1;
            end else begin
              start_ok_s = 1'b1;
              state_nx_s = ST_LAUNCH;
            end
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_LAUNCH: state_nx_s = ST_RUN;
        ST_RUN: begin
          if (MinerVld_I) begin
            find_s     = 1'b1;
            state_nx_s = ST_DONE;
          end else if (limit_hit_s) begin
            limit_s    = 1'b1;
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Host blob writes; the buffer itself is deliberately left unreset.
  always_ff @(posedge Clk) begin
    if (wr_ok_s) buf_r[WrAddr_I[4 +: PTR_W]][{WrAddr_I[3:0], 5'd0} +: 32] <= WrData_I;
  end

  // Chunk pointer: rewinds on every job boundary and hash completion, saturates at the last chunk.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_r <= '0;
    end else if (Abort_I || start_ok_s || find_s || limit_s) begin
      ptr_r <= '0;
    end else if (state_r == ST_RUN) begin
      if (MinerRdy_I)       ptr_r <= '0;
      else if (MinerNext_I) ptr_r <= (ptr_r >= last_s) ? last_s : (ptr_r + PTR_W'(1));
    end
  end

  // Registered outputs, latched job parameters and captured results.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      update_r    <= 1'b0;
      clear_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      found_r     <= 1'b0;
      err_r       <= 1'b0;
      msg_r       <= 512'd0;
      bytenum_r   <= 11'd0;
      nonce_r     <= '0;
      limit_r     <= 32'd0;
      res_nonce_r <= '0;
      res_hash_r  <= 256'd0;
    end else begin
      update_r <= (state_nx_s == ST_LAUNCH);
      busy_r   <= (state_nx_s == ST_LAUNCH) || (state_nx_s == ST_RUN);
      clear_r  <= Abort_I || find_s || limit_s;
      if (Abort_I || start_ok_s) begin
        done_r  <= 1'b0;
        found_r <= 1'b0;
      end else if (find_s || limit_s) begin
        done_r  <= 1'b1;
        found_r <= find_s;
      end
      err_r <= (err_r && !start_ok_s) || start_bad_s || wr_bad_s;
      if (start_ok_s) begin
        bytenum_r <= ByteNum_I;
        nonce_r   <= Nonce_I;
        limit_r   <= HashLimit_I;
      end
      if (find_s) begin
        res_nonce_r <= MinerNonce_I;
        res_hash_r  <= MinerHash_I;
      end
      msg_r <= buf_r[ptr_r];
    end
  end

  assign MinerUpdate_O  = update_r;
  assign MinerClear_O   = clear_r;
  assign MinerMsg_O     = msg_r;
  assign MinerByteNum_O = bytenum_r;
  assign MinerNonce_O   = nonce_r;
  assign Busy_O         = busy_r;
  assign Done_O         = done_r;
  assign Found_O        = found_r;
  assign Err_O          = err_r;
  assign ResNonce_O     = res_nonce_r;
  assign ResHash_O      = res_hash_r;

endmodule

// File: tb/tb_miner_job_feeder.sv
// Directed bench for miner_job_feeder: table-driven chunk pointer walk plus hand-written job sequences.
module tb_miner_job_feeder;

  localparam int NW = 192;

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic           WrEn_I, Start_I, Abort_I;
  logic [7:0]     WrAddr_I;
  logic [31:0]    WrData_I, HashLimit_I, MinerHashCnt_I;
  logic [10:0]    ByteNum_I, MinerByteNum_O;
  logic [NW-1:0]  Nonce_I, MinerNonce_O, MinerNonce_I, ResNonce_O;
  logic           MinerUpdate_O, MinerClear_O, MinerNext_I, MinerRdy_I, MinerVld_I;
  logic [511:0]   MinerMsg_O;
  logic [255:0]   MinerHash_I, ResHash_O;
  logic           Busy_O, Done_O, Found_O, Err_O;

  miner_job_feeder dut (
    .Clk(Clk), .Rst_n(Rst_n), .WrEn_I(WrEn_I), .WrAddr_I(WrAddr_I), .WrData_I(WrData_I),
    .Start_I(Start_I), .Abort_I(Abort_I), .ByteNum_I(ByteNum_I), .Nonce_I(Nonce_I),
    .HashLimit_I(HashLimit_I), .MinerUpdate_O(MinerUpdate_O), .MinerClear_O(MinerClear_O),
    .MinerMsg_O(MinerMsg_O), .MinerByteNum_O(MinerByteNum_O), .MinerNonce_O(MinerNonce_O),
    .MinerNext_I(MinerNext_I), .MinerRdy_I(MinerRdy_I), .MinerVld_I(MinerVld_I),
    .MinerHash_I(MinerHash_I), .MinerNonce_I(MinerNonce_I), .MinerHashCnt_I(MinerHashCnt_I),
    .Busy_O(Busy_O), .Done_O(Done_O), .Found_O(Found_O), .Err_O(Err_O),
    .ResNonce_O(ResNonce_O), .ResHash_O(ResHash_O)
  );

  always #5 Clk = ~Clk;

  int upd_cnt = 0;
  int clr_cnt = 0;
  // Pulse counters, sampled at each rising edge.
  always @(posedge Clk) begin
    if (MinerUpdate_O) upd_cnt <= upd_cnt + 1;
    if (MinerClear_O)  clr_cnt <= clr_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [511:0] chunk_exp(input int c);
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = {8'hA5, 8'(c), 8'h00, 8'(w)};
    return v;
  endfunction

  task automatic pulse_next(input logic nx, input logic rd);
    MinerNext_I = nx;
    MinerRdy_I  = rd;
    tick();
    MinerNext_I = 1'b0;
    MinerRdy_I  = 1'b0;
    tick();
  endtask

  task automatic start_job(input logic [10:0] bn, input logic [NW-1:0] nn, input logic [31:0] lim);
    ByteNum_I   = bn;
    Nonce_I     = nn;
    HashLimit_I = lim;
    Start_I     = 1'b1;
    tick();
    Start_I     = 1'b0;
  endtask

  typedef struct {
    logic nxt;
    logic rdy;
    int   exp_chunk;
  } vec_t;

  vec_t vecs [12];

  localparam logic [NW-1:0]  N1 = 192'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF_0102_0304_0506_0708;
  localparam logic [NW-1:0]  N2 = 192'hCAFE_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_BEEF;
  localparam logic [255:0]   HA = {32{8'hAB}};
  localparam logic [255:0]   HB = {32{8'h5C}};

  initial begin
    int u0, c0;
    vecs[0]  = '{1'b1, 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 2};
    vecs[2]  = '{1'b1, 1'b1, 0};
    vecs[3]  = '{1'b1, 1'b0, 1};
    vecs[4]  = '{1'b1, 1'b0, 2};
    vecs[5]  = '{1'b1, 1'b0, 3};
    vecs[6]  = '{1'b1, 1'b0, 3};
    vecs[7]  = '{1'b1, 1'b0, 3};
    vecs[8]  = '{1'b0, 1'b1, 0};
    vecs[9]  = '{1'b0, 1'b0, 0};
    vecs[10] = '{1'b1, 1'b0, 1};
    vecs[11] = '{1'b0, 1'b1, 0};

    Rst_n = 1'b0; WrEn_I = 1'b0; WrAddr_I = 8'd0; WrData_I = 32'd0;
    Start_I = 1'b0; Abort_I = 1'b0; ByteNum_I = 11'd0; Nonce_I = '0; HashLimit_I = 32'd0;
    MinerNext_I = 1'b0; MinerRdy_I = 1'b0; MinerVld_I = 1'b0; MinerHash_I = 256'd0;
    MinerNonce_I = '0; MinerHashCnt_I = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_outs", {MinerUpdate_O, MinerClear_O, Busy_O, Done_O, Found_O, Err_O}, 512'd0);
    chk("rst_msg", MinerMsg_O, 512'd0);
    chk("rst_res", {ResNonce_O, ResHash_O, MinerNonce_O, MinerByteNum_O}, 512'd0);
    Rst_n = 1'b1;
    tick();

    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 16; w++) begin
        WrEn_I   = 1'b1;
        WrAddr_I = {4'(c), 4'(w)};
        WrData_I = {8'hA5, 8'(c), 8'h00, 8'(w)};
        tick();
      end
    end
    WrEn_I = 1'b0;
    tick();

    // 100-byte job: two chunks
    u0 = upd_cnt;
    start_job(11'd100, N1, 32'd0);
    chk("launch_upd", MinerUpdate_O, 1);
    chk("launch_busy", Busy_O, 1);
    chk("launch_msg", MinerMsg_O, chunk_exp(0));
    chk("launch_bn", MinerByteNum_O, 100);
    chk("launch_nonce", MinerNonce_O, N1);
    tick();
    chk("upd_one_cycle", MinerUpdate_O, 0);
    pulse_next(1'b1, 1'b0);
    chk("next_chunk1", MinerMsg_O, chunk_exp(1));
    chk("upd_count", upd_cnt - u0, 1);
    pulse_next(1'b1, 1'b0);
    chk("next_sat_last", MinerMsg_O, chunk_exp(1));
    pulse_next(1'b0, 1'b1);
    chk("rdy_chunk0", MinerMsg_O, chunk_exp(0));

    // find; second Vld cycle must not overwrite results
    c0 = clr_cnt;
    MinerVld_I = 1'b1; MinerNonce_I = 192'h1234; MinerHash_I = HA;
    tick();
    MinerNonce_I = 192'h5555; MinerHash_I = HB;
    tick();
    MinerVld_I = 1'b0;
    tick(); tick();
    chk("res_nonce", ResNonce_O, 192'h1234);
    chk("res_hash", ResHash_O, HA);
    chk("found_done", {Done_O, Found_O, Busy_O}, 3'b110);
    chk("find_clr_cnt", clr_cnt - c0, 1);

    // oversize blob refused
    u0 = upd_cnt;
    start_job(11'd1100, N2, 32'd0);
    chk("bad_bn_err", Err_O, 1);
    tick(); tick();
    chk("bad_bn_state", {Busy_O, Done_O, Found_O}, 3'b011);
    chk("bad_bn_no_upd", upd_cnt - u0, 0);

    // 200-byte job: table-driven pointer walk (last chunk = 3)
    start_job(11'd200, N2, 32'd5);
    chk("job2_flags", {Busy_O, Done_O, Found_O, Err_O}, 4'b1000);
    tick();
    for (int i = 0; i < 12; i++) begin
      pulse_next(vecs[i].nxt, vecs[i].rdy);
      chk($sformatf("vec%0d_chunk", i), MinerMsg_O, chunk_exp(vecs[i].exp_chunk));
    end

    // write while busy is dropped and flagged
    WrEn_I = 1'b1; WrAddr_I = 8'h00; WrData_I = 32'hDEAD_BEEF;
    tick();
    WrEn_I = 1'b0;
    chk("wr_busy_err", Err_O, 1);
    tick();
    chk("wr_busy_dropped", MinerMsg_O, chunk_exp(0));

    // hash limit 5
    MinerHashCnt_I = 32'd4;
    tick(); tick();
    chk("below_limit_busy", {Busy_O, Done_O}, 2'b10);
    c0 = clr_cnt;
    MinerHashCnt_I = 32'd5;
    tick(); tick(); tick();
`ifdef FEEDER_TIMEOUT_EN
    chk("limit_flags", {Busy_O, Done_O, Found_O}, 3'b010);
    chk("limit_clr_cnt", clr_cnt - c0, 1);
    MinerHashCnt_I = 32'd0;
    start_job(11'd200, N2, 32'd0);
    tick();
`else
    chk("nolimit_flags", {Busy_O, Done_O, Found_O}, 3'b100);
    chk("nolimit_clr_cnt", clr_cnt - c0, 0);
    MinerHashCnt_I = 32'd0;
`endif

    // abort and find in the same cycle: abort wins
    c0 = clr_cnt;
    Abort_I = 1'b1; MinerVld_I = 1'b1; MinerNonce_I = 192'h9999; MinerHash_I = HB;
    tick();
    Abort_I = 1'b0; MinerVld_I = 1'b0;
    tick(); tick();
    chk("abort_flags", {Busy_O, Done_O, Found_O}, 3'b000);
    chk("abort_res_nonce", ResNonce_O, 192'h1234);
    chk("abort_res_hash", ResHash_O, HA);
    chk("abort_clr_cnt", clr_cnt - c0, 1);

    // single-chunk job, then async reset mid-run
    start_job(11'd64, N2, 32'd0);
    chk("job64_msg", MinerMsg_O, chunk_exp(0));
    chk("job64_bn", MinerByteNum_O, 64);
    tick();
    pulse_next(1'b1, 1'b0);
    chk("job64_sat", MinerMsg_O, chunk_exp(0));
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midrst_outs", {MinerUpdate_O, MinerClear_O, Busy_O, Done_O, Found_O, Err_O}, 512'd0);
    chk("midrst_msg", MinerMsg_O, 512'd0);
    chk("midrst_res", {ResNonce_O, ResHash_O, MinerNonce_O, MinerByteNum_O}, 512'd0);
    tick();
    Rst_n = 1'b1;
    tick();
    u0 = upd_cnt;
    start_job(11'd100, N1, 32'd0);
    chk("relaunch_upd", {MinerUpdate_O, Busy_O}, 2'b11);
    chk("relaunch_msg", MinerMsg_O, chunk_exp(0));
    chk("relaunch_nonce", MinerNonce_O, N1);
    tick();
    pulse_next(1'b1, 1'b0);
    chk("relaunch_chunk1", MinerMsg_O, chunk_exp(1));
    chk("relaunch_upd_cnt", upd_cnt - u0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
